// File: rtl/noc_edge_endpoint.sv
// noc_edge_endpoint
//   Credit-based peer for one mesh edge port of the noc top. It injects user
//   flits into the noc within the credits the noc returns, and it buffers the
//   flits the noc emits in a small FIFO, returning one credit for every flit
//   the user consumes.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   link_flit_out/_wr                flit and write strobe into the noc (registered)
//   link_credit_in                   credit pulse returned by the noc
//   link_flit_in/_wr                 flit and write strobe from the noc
//   link_credit_out                  credit pulse to the noc, one per RX pop (registered)
//   tx_flit, tx_valid, tx_ready      user TX handshake
//   rx_flit, rx_valid, rx_ready      user RX handshake, first-word fall-through
//   tx_credits                       current TX credit count
//   link_err                         sticky: [0] RX overflow, [1] credit overflow
//   stat_clr, tx_flit_cnt, rx_flit_cnt   statistics
//
// Build option
//   LINK_STATS_EN  when defined, tx_flit_cnt/rx_flit_cnt are saturating 16-bit
//                  counters cleared by stat_clr; otherwise both read 0.

module noc_edge_endpoint #(
  parameter int unsigned FW = 36,
  parameter int unsigned B  = 4,
  parameter int unsigned CW = $clog2(B + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [FW-1:0] link_flit_out,
  output logic          link_flit_out_wr,
  input  logic          link_credit_in,
  input  logic [FW-1:0] link_flit_in,
  input  logic          link_flit_in_wr,
  output logic          link_credit_out,
  input  logic [FW-1:0] tx_flit,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [FW-1:0] rx_flit,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CW-1:0] tx_credits,
  output logic [1:0]    link_err,
  input  logic          stat_clr,
  output logic [15:0]   tx_flit_cnt,
  output logic [15:0]   rx_flit_cnt
);

  localparam int unsigned PW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(B);

  // ---------------------------------------------------------------- TX path
  logic [CW-1:0] credits;
  logic          send;
  logic          err_credit;

  assign tx_ready   = (credits != '0);
  assign send       = tx_valid && tx_ready;
  assign tx_credits = credits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_flit_out    <= '0;
      link_flit_out_wr <= 1'b0;
      credits          <= CNT_MAX;
      err_credit       <= 1'b0;
    end else begin
      link_flit_out_wr <= send;
      if (send) link_flit_out <= tx_flit;
      // A send and a returned credit in the same cycle cancel out.
      unique case ({send, link_credit_in})
        2'b10: credits <= credits - CNT_ONE;
        2'b01: begin
          if (credits == CNT_MAX) err_credit <= 1'b1;
          else                    credits    <= credits + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [FW-1:0] mem [B];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] occ;
  logic          pop, full, wr_acc;
  logic          err_rx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(B - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rx_valid = (occ != '0);
  assign rx_flit  = mem[rd_ptr];
  assign pop      = rx_valid && rx_ready;
  assign full     = (occ == CNT_MAX);
  // A pop in the same cycle frees the head slot, so a write to a full FIFO
  // is still accepted (it lands where the popped head was).
  assign wr_acc   = link_flit_in_wr && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= link_flit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      occ             <= '0;
      link_credit_out <= 1'b0;
      err_rx          <= 1'b0;
    end else begin
      link_credit_out <= pop;
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr_acc, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: ;
      endcase
      if (link_flit_in_wr && !wr_acc) err_rx <= 1'b1;
    end
  end

  assign link_err = {err_credit, err_rx};

  // ------------------------------------------------------------- statistics
`ifdef LINK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_flit_cnt <= '0;
      rx_flit_cnt <= '0;
    end else if (stat_clr) begin
      tx_flit_cnt <= '0;
      rx_flit_cnt <= '0;
    end else begin
      if (link_flit_out_wr && (tx_flit_cnt != '1)) tx_flit_cnt <= tx_flit_cnt + 16'd1;
      if (wr_acc && (rx_flit_cnt != '1))           rx_flit_cnt <= rx_flit_cnt + 16'd1;
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign tx_flit_cnt     = '0;
  assign rx_flit_cnt     = '0;
`endif

endmodule

// File: tb/tb_noc_edge_endpoint.sv
module tb_noc_edge_endpoint;

  localparam int FW = 36;
  localparam int B  = 4;
  localparam int CW = 3;
`ifdef LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] link_flit_out;
  logic          link_flit_out_wr;
  logic          link_credit_in = 1'b0;
  logic [FW-1:0] link_flit_in = '0;
  logic          link_flit_in_wr = 1'b0;
  logic          link_credit_out;
  logic [FW-1:0] tx_flit = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [FW-1:0] rx_flit;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [CW-1:0] tx_credits;
  logic [1:0]    link_err;
  logic          stat_clr = 1'b0;
  logic [15:0]   tx_flit_cnt;
  logic [15:0]   rx_flit_cnt;

  noc_edge_endpoint #(.FW(FW), .B(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .link_flit_out(link_flit_out), .link_flit_out_wr(link_flit_out_wr),
    .link_credit_in(link_credit_in),
    .link_flit_in(link_flit_in), .link_flit_in_wr(link_flit_in_wr),
    .link_credit_out(link_credit_out),
    .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_credits(tx_credits), .link_err(link_err), .stat_clr(stat_clr),
    .tx_flit_cnt(tx_flit_cnt), .rx_flit_cnt(rx_flit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: credit count as an integer, RX FIFO as a queue.
  int            m_cred;
  logic          m_wr;
  logic [FW-1:0] m_out;
  logic          m_cout;
  logic [1:0]    m_err;
  logic [FW-1:0] m_q[$];
  int            m_txc, m_rxc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred = B; m_wr = 1'b0; m_out = '0; m_cout = 1'b0; m_err = 2'b00;
    m_q.delete(); m_txc = 0; m_rxc = 0;
  endtask

  task automatic check_model();
    chk("link_flit_out_wr", 64'(link_flit_out_wr), 64'(m_wr));
    chk("link_flit_out", 64'(link_flit_out), 64'(m_out));
    chk("tx_credits", 64'(tx_credits), 64'(m_cred));
    chk("tx_ready", 64'(tx_ready), 64'(m_cred != 0));
    chk("rx_valid", 64'(rx_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk("rx_flit", 64'(rx_flit), 64'(m_q[0]));
    chk("link_credit_out", 64'(link_credit_out), 64'(m_cout));
    chk("link_err", 64'(link_err), 64'(m_err));
    chk("tx_flit_cnt", 64'(tx_flit_cnt), 64'(m_txc));
    chk("rx_flit_cnt", 64'(rx_flit_cnt), 64'(m_rxc));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic tv, input logic [FW-1:0] tf, input logic ci,
                      input logic fw, input logic [FW-1:0] ff, input logic rr,
                      input logic sc);
    logic snd, pp, acc;
    tx_valid = tv; tx_flit = tf; link_credit_in = ci;
    link_flit_in_wr = fw; link_flit_in = ff; rx_ready = rr; stat_clr = sc;
    snd = tv && (m_cred > 0);
    if (STATS) begin
      if (sc) m_txc = 0;
      else if (m_wr && m_txc < 16'hFFFF) m_txc++;
    end
    m_wr = snd;
    if (snd) m_out = tf;
    m_cred = m_cred + int'(ci) - int'(snd);
    if (m_cred > B) begin m_cred = B; m_err[1] = 1'b1; end
    pp  = (m_q.size() != 0) && rr;
    acc = fw && ((m_q.size() < B) || pp);
    if (pp) void'(m_q.pop_front());
    if (acc) m_q.push_back(ff);
    else if (fw) m_err[0] = 1'b1;
    m_cout = pp;
    if (STATS) begin
      if (sc) m_rxc = 0;
      else if (acc && m_rxc < 16'hFFFF) m_rxc++;
    end
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    tx_valid = 1'b0; tx_flit = '0; link_credit_in = 1'b0;
    link_flit_in_wr = 1'b0; link_flit_in = '0; rx_ready = 1'b0; stat_clr = 1'b0;
    #3;
    chk("rst_flit_out_wr", 64'(link_flit_out_wr), 64'd0);
    chk("rst_flit_out", 64'(link_flit_out), 64'd0);
    chk("rst_credits", 64'(tx_credits), 64'd4);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_credit_out", 64'(link_credit_out), 64'd0);
    chk("rst_link_err", 64'(link_err), 64'd0);
    chk("rst_cnts", {32'd0, tx_flit_cnt, rx_flit_cnt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain_expect(input logic [FW-1:0] e);
    chk("drain_valid", 64'(rx_valid), 64'd1);
    chk("drain_flit", 64'(rx_flit), 64'(e));
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("drain_credit_pulse", 64'(link_credit_out), 64'd1);
  endtask

  typedef struct {
    logic          tv;
    logic [FW-1:0] tf;
    logic          ci;
    logic          e_wr;
    logic [FW-1:0] e_out;
    logic [CW-1:0] e_cr;
    logic          e_rdy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Credit exhaustion, single credit return, held 5th flit.
    tbl[0] = '{1'b1, 36'h1, 1'b0, 1'b1, 36'h1, 3'd3, 1'b1};
    tbl[1] = '{1'b1, 36'h2, 1'b0, 1'b1, 36'h2, 3'd2, 1'b1};
    tbl[2] = '{1'b1, 36'h3, 1'b0, 1'b1, 36'h3, 3'd1, 1'b1};
    tbl[3] = '{1'b1, 36'h4, 1'b0, 1'b1, 36'h4, 3'd0, 1'b0};
    tbl[4] = '{1'b1, 36'h5, 1'b0, 1'b0, 36'h4, 3'd0, 1'b0};
    tbl[5] = '{1'b1, 36'h5, 1'b1, 1'b0, 36'h4, 3'd1, 1'b1};
    tbl[6] = '{1'b1, 36'h5, 1'b0, 1'b1, 36'h5, 3'd0, 1'b0};
    tbl[7] = '{1'b0, 36'h5, 1'b0, 1'b0, 36'h5, 3'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].tv, tbl[i].tf, tbl[i].ci, 1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_wr", i), 64'(link_flit_out_wr), 64'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_out", i), 64'(link_flit_out), 64'(tbl[i].e_out));
      chk($sformatf("tbl%0d_credits", i), 64'(tx_credits), 64'(tbl[i].e_cr));
      chk($sformatf("tbl%0d_ready", i), 64'(tx_ready), 64'(tbl[i].e_rdy));
    end

    // RX ordering and per-pop credit pulses.
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 36'hA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 36'hB, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 36'hC, 1'b0, 1'b0);
    chk("rx3_no_credit_yet", 64'(link_credit_out), 64'd0);
    drain_expect(36'hA);
    drain_expect(36'hB);
    drain_expect(36'hC);
    chk("rx3_empty", 64'(rx_valid), 64'd0);
    idle();
    chk("rx3_credit_done", 64'(link_credit_out), 64'd0);

    // Overflow with no pop: 5th flit dropped.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, '0, 1'b0, 1'b1, 36'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 36'h5, 1'b0, 1'b0);
    chk("ovf_err", 64'(link_err), 64'b01);
    for (int i = 1; i <= 4; i++) drain_expect(36'(i));
    chk("ovf_empty", 64'(rx_valid), 64'd0);

    // Full write with simultaneous pop: accepted, no error.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, '0, 1'b0, 1'b1, 36'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 36'h5, 1'b1, 1'b0);
    chk("fullpop_err", 64'(link_err), 64'b00);
    for (int i = 2; i <= 5; i++) drain_expect(36'(i));
    chk("fullpop_empty", 64'(rx_valid), 64'd0);

    // Send and credit return cancel; credit overflow at B.
    do_reset();
    step(1'b1, 36'h11, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 36'h12, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 36'h13, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("cancel_credits", 64'(tx_credits), 64'd2);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("refill_credits", 64'(tx_credits), 64'd4);
    chk("refill_no_err", 64'(link_err), 64'b00);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("cov_credits", 64'(tx_credits), 64'd4);
    chk("cov_err", 64'(link_err), 64'b10);

    // Statistics and clear.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 36'(i + 32), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle();
    step(1'b0, '0, 1'b0, 1'b1, 36'h21, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 36'h22, 1'b0, 1'b0);
    idle();
    chk("stats_tx", 64'(tx_flit_cnt), STATS ? 64'd3 : 64'd0);
    chk("stats_rx", 64'(rx_flit_cnt), STATS ? 64'd2 : 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("stats_clr_tx", 64'(tx_flit_cnt), 64'd0);
    chk("stats_clr_rx", 64'(rx_flit_cnt), 64'd0);

    // Randomised traffic against the model, then a mid-traffic reset.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] r1, r2;
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      step($urandom_range(0, 3) != 0, r1[FW-1:0], $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, r2[FW-1:0], $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0);
    end
    do_reset();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
